// File: rtl/fu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fu_pkg
//  Brief    : Shared constants for the func_unit_seq datapath function unit:
//             function-select codes, FSM state encodings, default widths.
//  Revision : 1.0 - initial release
// ============================================================================
package fu_pkg;

   localparam int FU_WIDTH = 32;
   localparam int FU_FS_W  = 5;

   // Function-select encodings
   localparam logic [4:0] FS_ADD  = 5'd0;
   localparam logic [4:0] FS_SUB  = 5'd1;
   localparam logic [4:0] FS_AND  = 5'd2;
   localparam logic [4:0] FS_OR   = 5'd3;
   localparam logic [4:0] FS_XOR  = 5'd4;
   localparam logic [4:0] FS_NOT  = 5'd5;
   localparam logic [4:0] FS_SLL  = 5'd6;
   localparam logic [4:0] FS_SRL  = 5'd7;
   localparam logic [4:0] FS_SRA  = 5'd8;
   localparam logic [4:0] FS_PASA = 5'd9;
   localparam logic [4:0] FS_PASB = 5'd10;
   localparam logic [4:0] FS_SLT  = 5'd11;
   localparam logic [4:0] FS_MUL  = 5'd12;

   // FSM state encodings
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MULT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/func_unit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : func_unit_seq_if
//  Brief    : Operand/result bundle between the operand muxes and the
//             function unit. master = requester, slave = func_unit_seq.
//  Revision : 1.0 - initial release
// ============================================================================
interface func_unit_seq_if #(
   parameter int WIDTH = fu_pkg::FU_WIDTH,
   parameter int FS_W  = fu_pkg::FU_FS_W
);
   logic [WIDTH-1:0] bus_a;
   logic [WIDTH-1:0] bus_b;
   logic [FS_W-1:0]  fs;
   logic             start;
   logic [WIDTH-1:0] f;
   logic             v;
   logic             c;
   logic             n;
   logic             z;
   logic             busy;
   logic             done;

   modport master (
      output bus_a, bus_b, fs, start,
      input  f, v, c, n, z, busy, done
   );

   modport slave (
      input  bus_a, bus_b, fs, start,
      output f, v, c, n, z, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/fu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fu_mul_iter
//  Brief    : Iterative shift-add multiplier, one partial product per cycle,
//             WIDTH iterations. o_done/o_product are combinational and valid
//             during the final iteration so the parent can register the
//             result on the same edge the multiplier goes idle.
//             Only present when FU_MUL_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef FU_MUL_EN
module fu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [WIDTH-1:0] w_step;

   // Accumulator value after this cycle's conditional add
   assign w_step    = r_b[0] ? (r_acc + r_a) : r_acc;
   assign o_product = w_step;
   assign o_done    = r_busy && (r_cnt == CNT_W'(1));
   assign o_busy    = r_busy;

   // Operand capture on start, then one shift-add step per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_a    <= i_a;
         r_b    <= i_b;
         r_acc  <= '0;
         r_cnt  <= CNT_W'(WIDTH);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_acc <= w_step;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end
endmodule
`endif
`default_nettype wire

// File: rtl/func_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : func_unit_seq
//  Brief    : Datapath function unit. Single-cycle ALU/shifter ops with
//             registered result and V/C/N/Z flags; optional iterative
//             multiply (FS=12) taking WIDTH+1 cycles.
//             Build option: FU_MUL_EN - when defined, MUL is implemented via
//             fu_mul_iter; when undefined, FS=12 behaves as a reserved code.
//  Revision : 1.0 - initial release
// ============================================================================
module func_unit_seq
   import fu_pkg::*;
#(
   parameter int WIDTH = FU_WIDTH,
   parameter int FS_W  = FU_FS_W
) (
   input  logic           clk,
   input  logic           rst,
   func_unit_seq_if.slave bus
);
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [FS_W-1:0]  w_fs;
   logic [4:0]       w_shamt;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_f;
   logic             w_alu_c;
   logic             w_alu_v;

   logic             w_idle;
   logic             w_is_mul;
   logic             w_accept_op;

   logic [WIDTH-1:0] r_f;
   logic             r_v;
   logic             r_c;
   logic             r_n;
   logic             r_z;
   logic             r_done;

   assign w_a     = bus.bus_a;
   assign w_b     = bus.bus_b;
   assign w_fs    = bus.fs;
   assign w_shamt = w_b[4:0];

`ifdef FU_MUL_EN
   logic [0:0]       r_state;
   logic             w_mul_start;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;

   assign w_idle      = (r_state == ST_IDLE) && !w_mul_busy;
   assign w_is_mul    = (w_fs == FS_MUL);
   assign w_mul_start = bus.start && w_idle && w_is_mul;

   fu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (w_a),
      .i_b       (w_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   assign bus.busy = (r_state == ST_MULT);
`else
   assign w_idle   = 1'b1;
   assign w_is_mul = 1'b0;
   assign bus.busy = 1'b0;
`endif

   // Any non-multiply request is accepted only while nothing is in flight
   assign w_accept_op = bus.start && w_idle && !w_is_mul;

   // Single-cycle ALU/shifter; carry and overflow only meaningful for ADD/SUB
   always_comb begin
      w_alu_f = '0;
      w_alu_c = 1'b0;
      w_alu_v = 1'b0;
      w_sum   = '0;
      case (w_fs)
         FS_ADD: begin
            w_sum   = {1'b0, w_a} + {1'b0, w_b};
            w_alu_f = w_sum[WIDTH-1:0];
            w_alu_c = w_sum[WIDTH];
            w_alu_v = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                      (w_alu_f[WIDTH-1] != w_a[WIDTH-1]);
         end
         FS_SUB: begin
            // A + ~B + 1: carry-out set means no borrow
            w_sum   = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
            w_alu_f = w_sum[WIDTH-1:0];
            w_alu_c = w_sum[WIDTH];
            w_alu_v = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                      (w_alu_f[WIDTH-1] != w_a[WIDTH-1]);
         end
         FS_AND:  w_alu_f = w_a & w_b;
         FS_OR:   w_alu_f = w_a | w_b;
         FS_XOR:  w_alu_f = w_a ^ w_b;
         FS_NOT:  w_alu_f = ~w_a;
         FS_SLL:  w_alu_f = w_a << w_shamt;
         FS_SRL:  w_alu_f = w_a >> w_shamt;
         FS_SRA:  w_alu_f = $signed(w_a) >>> w_shamt;
         FS_PASA: w_alu_f = w_a;
         FS_PASB: w_alu_f = w_b;
         FS_SLT:  w_alu_f = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         default: w_alu_f = '0;
      endcase
   end

   // Result/flag registers, DONE pulse and IDLE/MULT sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         r_f    <= '0;
         r_v    <= 1'b0;
         r_c    <= 1'b0;
         r_n    <= 1'b0;
         r_z    <= 1'b0;
         r_done <= 1'b0;
`ifdef FU_MUL_EN
         r_state <= ST_IDLE;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept_op) begin
            r_f    <= w_alu_f;
            r_v    <= w_alu_v;
            r_c    <= w_alu_c;
            r_n    <= w_alu_f[WIDTH-1];
            r_z    <= (w_alu_f == '0);
            r_done <= 1'b1;
         end
`ifdef FU_MUL_EN
         else if (w_mul_start) begin
            r_state <= ST_MULT;
         end else if ((r_state == ST_MULT) && w_mul_done) begin
            r_f     <= w_mul_product;
            r_v     <= 1'b0;
            r_c     <= 1'b0;
            r_n     <= w_mul_product[WIDTH-1];
            r_z     <= (w_mul_product == '0);
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
         end
`endif
      end
   end

   assign bus.f    = r_f;
   assign bus.v    = r_v;
   assign bus.c    = r_c;
   assign bus.n    = r_n;
   assign bus.z    = r_z;
   assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_func_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_func_unit_seq
//  Brief    : Self-checking bench for func_unit_seq: directed vectors,
//             back-to-back issue, randomized ops against a behavioural model,
//             reserved codes, reset behaviour and (with FU_MUL_EN) multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_func_unit_seq;
   import fu_pkg::*;

   localparam int W = 32;
`ifdef FU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] f;
      logic         v;
      logic         c;
      logic         n;
      logic         z;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   func_unit_seq_if #(.WIDTH(W), .FS_W(5)) ifc ();

   func_unit_seq #(.WIDTH(W), .FS_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // Reference model: results derived from arithmetic definitions
   function automatic res_t model(input logic [4:0] fs, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      res_t        r;
      longint      sa;
      longint      sb;
      longint      s;
      logic [63:0] u;
      r  = '0;
      sa = $signed(a);
      sb = $signed(b);
      case (fs)
         5'd0: begin
            u   = {32'b0, a} + {32'b0, b};
            r.f = u[31:0];
            r.c = u[32];
            s   = sa + sb;
            r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'd1: begin
            r.f = a - b;
            r.c = (a >= b);
            s   = sa - sb;
            r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'd2:  r.f = a & b;
         5'd3:  r.f = a | b;
         5'd4:  r.f = a ^ b;
         5'd5:  r.f = ~a;
         5'd6:  r.f = a << b[4:0];
         5'd7:  r.f = a >> b[4:0];
         5'd8:  r.f = $signed(a) >>> b[4:0];
         5'd9:  r.f = a;
         5'd10: r.f = b;
         5'd11: r.f = (sa < sb) ? 32'd1 : 32'd0;
         5'd12: begin
            u   = {32'b0, a} * {32'b0, b};
            r.f = MUL_EN ? u[31:0] : 32'd0;
         end
         default: r.f = 32'd0;
      endcase
      r.z = (r.f == 32'd0);
      r.n = r.f[31];
      return r;
   endfunction

   task automatic drive(input logic s, input logic [4:0] fs,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      ifc.start = s;
      ifc.fs    = fs;
      ifc.bus_a = a;
      ifc.bus_b = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, FS_ADD, 32'h1234_5678, 32'h1);
      rst = 1'b1;
      tick();
      tick();
      checks++; if (ifc.f !== 32'd0) begin errors++; $display("FAIL reset_f got=%h want=0", ifc.f); end
      checks++; if ({ifc.v, ifc.c, ifc.n, ifc.z} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b want=0000", {ifc.v, ifc.c, ifc.n, ifc.z}); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
      checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", ifc.done); end
      drive(1'b0, FS_ADD, 32'h0, 32'h0);
      rst = 1'b0;
      tick();
      checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_nodone got=%b want=0", ifc.done); end
   endtask

   task automatic test_directed();
      logic [4:0]   d_fs [5];
      logic [W-1:0] d_a  [5];
      logic [W-1:0] d_b  [5];
      logic [W-1:0] d_f  [5];
      logic [3:0]   d_fl [5];
      d_fs = '{FS_ADD, FS_SUB, FS_SUB, FS_SRA, FS_SLT};
      d_a  = '{32'h7FFF_FFFF, 32'd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF};
      d_b  = '{32'h0000_0001, 32'd5, 32'd1, 32'd4, 32'd1};
      d_f  = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hF800_0000, 32'd1};
      d_fl = '{4'b1010, 4'b0101, 4'b0010, 4'b0010, 4'b0000};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, d_fs[i], d_a[i], d_b[i]);
         tick();
         checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL dir_done[%0d] got=%b want=1", i, ifc.done); end
         checks++; if (ifc.f !== d_f[i]) begin errors++; $display("FAIL dir_f[%0d] got=%h want=%h", i, ifc.f, d_f[i]); end
         checks++; if ({ifc.v, ifc.c, ifc.n, ifc.z} !== d_fl[i]) begin errors++; $display("FAIL dir_flags[%0d] got=%b want=%b", i, {ifc.v, ifc.c, ifc.n, ifc.z}, d_fl[i]); end
         checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL dir_busy[%0d] got=%b want=0", i, ifc.busy); end
         drive(1'b0, FS_XOR, $urandom, $urandom);
         tick();
         checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL dir_pulse[%0d] got=%b want=0", i, ifc.done); end
         checks++; if (ifc.f !== d_f[i]) begin errors++; $display("FAIL dir_hold[%0d] got=%h want=%h", i, ifc.f, d_f[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]   fs;
      logic [W-1:0] a;
      logic [W-1:0] b;
      res_t         e;
      for (int i = 0; i < 6; i++) begin
         fs = 5'($urandom_range(0, 11));
         a  = $urandom;
         b  = $urandom;
         e  = model(fs, a, b);
         drive(1'b1, fs, a, b);
         tick();
         checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d] got=%b want=1", i, ifc.done); end
         checks++; if (ifc.f !== e.f) begin errors++; $display("FAIL b2b_f[%0d] fs=%0d got=%h want=%h", i, fs, ifc.f, e.f); end
      end
      drive(1'b0, FS_ADD, 32'd0, 32'd0);
      tick();
      checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b want=0", ifc.done); end
   endtask

   task automatic test_random();
      logic         s;
      logic [4:0]   fs;
      logic [W-1:0] a;
      logic [W-1:0] b;
      res_t         e;
      res_t         n;
      e = '{f: ifc.f, v: ifc.v, c: ifc.c, n: ifc.n, z: ifc.z};
      for (int i = 0; i < 300; i++) begin
         s  = ($urandom_range(0, 3) != 0);
         fs = 5'($urandom_range(0, 31));
         if (MUL_EN && fs == FS_MUL) fs = FS_SUB;
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) b = a;
         if ($urandom_range(0, 7) == 0) a = {a[31], 31'h7FFF_FFFF};
         drive(s, fs, a, b);
         tick();
         if (s) begin
            n = model(fs, a, b);
            e = n;
         end
         checks++; if (ifc.done !== s) begin errors++; $display("FAIL rnd_done[%0d] got=%b want=%b", i, ifc.done, s); end
         checks++; if (ifc.f !== e.f) begin errors++; $display("FAIL rnd_f[%0d] fs=%0d a=%h b=%h got=%h want=%h", i, fs, a, b, ifc.f, e.f); end
         checks++; if ({ifc.v, ifc.c, ifc.n, ifc.z} !== {e.v, e.c, e.n, e.z}) begin errors++; $display("FAIL rnd_flags[%0d] fs=%0d a=%h b=%h got=%b want=%b", i, fs, a, b, {ifc.v, ifc.c, ifc.n, ifc.z}, {e.v, e.c, e.n, e.z}); end
         checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rnd_busy[%0d] got=%b want=0", i, ifc.busy); end
      end
   endtask

   task automatic test_reserved();
      logic [4:0] codes [3];
      codes = '{5'd12, 5'd20, 5'd31};
      for (int i = 0; i < 3; i++) begin
         if (MUL_EN && codes[i] == FS_MUL) continue;
         drive(1'b1, FS_ADD, 32'h7FFF_FFFF, 32'd1);
         tick();
         drive(1'b1, codes[i], 32'd3, 32'd4);
         tick();
         checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL rsv_done[%0d] got=%b want=1", codes[i], ifc.done); end
         checks++; if (ifc.f !== 32'd0) begin errors++; $display("FAIL rsv_f[%0d] got=%h want=0", codes[i], ifc.f); end
         checks++; if ({ifc.v, ifc.c, ifc.n, ifc.z} !== 4'b0001) begin errors++; $display("FAIL rsv_flags[%0d] got=%b want=0001", codes[i], {ifc.v, ifc.c, ifc.n, ifc.z}); end
         checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rsv_busy[%0d] got=%b want=0", codes[i], ifc.busy); end
         drive(1'b0, FS_ADD, 32'd0, 32'd0);
         tick();
         checks++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin errors++; $display("FAIL rsv_after[%0d] got done=%b busy=%b want 0/0", codes[i], ifc.done, ifc.busy); end
      end
   endtask

   task automatic test_reset_clear();
      drive(1'b1, FS_ADD, 32'h7FFF_FFFF, 32'd1);
      tick();
      drive(1'b1, FS_ADD, 32'd5, 32'd6);
      rst = 1'b1;
      tick();
      checks++; if (ifc.f !== 32'd0) begin errors++; $display("FAIL rclr_f got=%h want=0", ifc.f); end
      checks++; if ({ifc.v, ifc.c, ifc.n, ifc.z} !== 4'b0000) begin errors++; $display("FAIL rclr_flags got=%b want=0000", {ifc.v, ifc.c, ifc.n, ifc.z}); end
      checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL rclr_done got=%b want=0", ifc.done); end
      drive(1'b0, FS_ADD, 32'd0, 32'd0);
      rst = 1'b0;
      tick();
      checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL rclr_nodone got=%b want=0", ifc.done); end
   endtask

`ifdef FU_MUL_EN
   task automatic test_mul();
      logic [W-1:0] ma [4];
      logic [W-1:0] mb [4];
      int           busy_cnt;
      int           done_cnt;
      int           done_at;
      int           both;
      logic [W-1:0] f_at;
      logic [3:0]   fl_at;
      res_t         e;
      ma[0] = 32'h0000_FFFF;
      mb[0] = 32'h0001_0001;
      for (int i = 1; i < 4; i++) begin
         ma[i] = $urandom;
         mb[i] = $urandom;
      end
      for (int t = 0; t < 4; t++) begin
         busy_cnt = 0;
         done_cnt = 0;
         done_at  = -1;
         both     = 0;
         f_at     = '0;
         fl_at    = '0;
         e        = model(FS_MUL, ma[t], mb[t]);
         drive(1'b1, FS_MUL, ma[t], mb[t]);
         tick();
         if (ifc.busy) busy_cnt++;
         if (ifc.done) done_cnt++;
         for (int k = 1; k <= 40; k++) begin
            drive(k == 4, FS_ADD, $urandom, $urandom);
            tick();
            if (ifc.busy) busy_cnt++;
            if (ifc.busy && ifc.done) both++;
            if (ifc.done) begin
               done_cnt++;
               if (done_at < 0) begin
                  done_at = k;
                  f_at    = ifc.f;
                  fl_at   = {ifc.v, ifc.c, ifc.n, ifc.z};
               end
            end
         end
         checks++; if (busy_cnt != W) begin errors++; $display("FAIL mul_busy_cycles[%0d] got=%0d want=%0d", t, busy_cnt, W); end
         checks++; if (done_at != W) begin errors++; $display("FAIL mul_done_at[%0d] got=%0d want=%0d", t, done_at, W); end
         checks++; if (done_cnt != 1) begin errors++; $display("FAIL mul_done_count[%0d] got=%0d want=1", t, done_cnt); end
         checks++; if (both != 0) begin errors++; $display("FAIL mul_busy_and_done[%0d] got=%0d want=0", t, both); end
         checks++; if (f_at !== e.f) begin errors++; $display("FAIL mul_f[%0d] a=%h b=%h got=%h want=%h", t, ma[t], mb[t], f_at, e.f); end
         checks++; if (fl_at !== {e.v, e.c, e.n, e.z}) begin errors++; $display("FAIL mul_flags[%0d] got=%b want=%b", t, fl_at, {e.v, e.c, e.n, e.z}); end
      end
   endtask

   task automatic test_mul_reset();
      int   done_cnt;
      int   busy_cnt;
      res_t e;
      drive(1'b1, FS_ADD, 32'h7FFF_FFFF, 32'd1);
      tick();
      drive(1'b1, FS_MUL, $urandom | 32'd1, $urandom | 32'd1);
      tick();
      for (int k = 1; k < 9; k++) begin
         drive(1'b0, FS_ADD, $urandom, $urandom);
         tick();
      end
      drive(1'b0, FS_ADD, 32'd0, 32'd0);
      rst = 1'b1;
      tick();
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b want=0", ifc.busy); end
      checks++; if (ifc.f !== 32'd0) begin errors++; $display("FAIL mrst_f got=%h want=0", ifc.f); end
      checks++; if ({ifc.v, ifc.c, ifc.n, ifc.z} !== 4'b0000) begin errors++; $display("FAIL mrst_flags got=%b want=0000", {ifc.v, ifc.c, ifc.n, ifc.z}); end
      done_cnt = (ifc.done === 1'b1) ? 1 : 0;
      busy_cnt = 0;
      drive(1'b0, FS_ADD, 32'd0, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (ifc.done) done_cnt++;
         if (ifc.busy) busy_cnt++;
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL mrst_no_done got=%0d want=0", done_cnt); end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL mrst_no_busy got=%0d want=0", busy_cnt); end
      e = model(FS_ADD, 32'h1234_5678, 32'h1111_1111);
      drive(1'b1, FS_ADD, 32'h1234_5678, 32'h1111_1111);
      tick();
      checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL mrst_add_done got=%b want=1", ifc.done); end
      checks++; if (ifc.f !== e.f) begin errors++; $display("FAIL mrst_add_f got=%h want=%h", ifc.f, e.f); end
      drive(1'b0, FS_ADD, 32'd0, 32'd0);
      tick();
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      ifc.start = 1'b0;
      ifc.fs    = '0;
      ifc.bus_a = '0;
      ifc.bus_b = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reserved();
      test_reset_clear();
`ifdef FU_MUL_EN
      test_mul();
      test_mul_reset();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
